window3x3_gen: RTL and testbench

// - Producer side of the 3x3 window bus (p1..p9) consumed by the filter pipeline stages.
// - Takes a raster-order pixel stream and builds each 3x3 neighbourhood using two line buffers.
// - Presents the window as registered p1..p9 with a qualifying valid.
// - Sits between the pixel source and the first filter stage; that stage and all later stages are free-running (no back-pressure).

---
 rtl/window3x3_gen_pkg.sv | 17 +
 rtl/window3x3_gen_if.sv | 43 ++++
 rtl/window3x3_gen_line_buffer.sv | 38 +++
 rtl/window3x3_gen.sv | 121 ++++++++++++
 tb/tb_window3x3_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window3x3_gen_pkg.sv
// ---------------------------------------------------------------------------
// window3x3_gen_pkg
// Shared types for the 3x3 window bus used by the filter pipeline.
//   PIX_W_DEFAULT : default pixel width in bits
//   pix_t         : one pixel
//   win_t         : a full window, packed p1..p9 (index 1 = top-left,
//                   index 5 = centre, index 9 = newest pixel); downstream
//                   stages use the same order
// ---------------------------------------------------------------------------
package window3x3_gen_pkg;

  localparam int PIX_W_DEFAULT = 8;

  typedef logic [PIX_W_DEFAULT-1:0] pix_t;
  typedef pix_t [1:9]               win_t;

endpackage

// File: rtl/window3x3_gen_if.sv
// ---------------------------------------------------------------------------
// window3x3_gen_if
// Pixel stream in, 3x3 window bus out.
//   sof, pix_valid, pix_in : raster-order pixel stream (sof marks pixel 0,0)
//   p1..p9                 : window, row-major, p5 = centre, p9 = newest
//   win_valid              : p1..p9 hold a complete interior window
//   frame_done             : one-cycle pulse after the last pixel of a frame
// Modports:
//   master : the window producer (consumes the stream, drives the window)
//   slave  : the environment around it (drives the stream, reads the window)
// ---------------------------------------------------------------------------
interface window3x3_gen_if
  import window3x3_gen_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT
) ();

  logic             sof;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_in;
  logic [PIX_W-1:0] p1;
  logic [PIX_W-1:0] p2;
  logic [PIX_W-1:0] p3;
  logic [PIX_W-1:0] p4;
  logic [PIX_W-1:0] p5;
  logic [PIX_W-1:0] p6;
  logic [PIX_W-1:0] p7;
  logic [PIX_W-1:0] p8;
  logic [PIX_W-1:0] p9;
  logic             win_valid;
  logic             frame_done;

  modport master (
    input  sof, pix_valid, pix_in,
    output p1, p2, p3, p4, p5, p6, p7, p8, p9, win_valid, frame_done
  );

  modport slave (
    output sof, pix_valid, pix_in,
    input  p1, p2, p3, p4, p5, p6, p7, p8, p9, win_valid, frame_done
  );

endinterface

// File: rtl/window3x3_gen_line_buffer.sv
// ---------------------------------------------------------------------------
// window3x3_gen_line_buffer
// One line of storage, DEPTH entries of WIDTH bits, single shared address.
//   clk   : clock
//   en    : write enable
//   addr  : read and write address
//   wdata : data written at addr when en=1
//   rdata : combinational read of addr (old contents during a write cycle)
// Contents are not reset; the window logic never trusts them until a full
// row has been written in the current frame.
// ---------------------------------------------------------------------------
module window3x3_gen_line_buffer
  import window3x3_gen_pkg::*;
#(
  parameter  int DEPTH = 640,
  parameter  int WIDTH = 2 * PIX_W_DEFAULT,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Asynchronous read so the caller sees the old entry in the same cycle
  // it overwrites it (read-before-write).
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window3x3_gen.sv
// ---------------------------------------------------------------------------
// window3x3_gen
// Builds 3x3 neighbourhoods from a raster-order pixel stream using two line
// buffers (held as one double-width buffer: low half = previous row,
// high half = the row before that) and three 3-deep column shift registers.
//   clk : clock, all logic on posedge
//   rst : asynchronous, active-low reset
//   bus : window3x3_gen_if.master (pixel stream in, window bus out)
// Parameters: IMG_W / IMG_H image size (each >= 3), PIX_W pixel width.
// Outputs update on the edge that accepts a pixel and are visible the
// following cycle. No back-pressure: every valid pixel is accepted.
// ---------------------------------------------------------------------------
module window3x3_gen
  import window3x3_gen_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  window3x3_gen_if.master bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0]          col_q, col_d, cur_col;
  logic [RW-1:0]          row_q, row_d, cur_row;
  logic [1:9][PIX_W-1:0]  win_q, win_d;
  logic                   win_valid_q, win_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic [2*PIX_W-1:0]     lb_rdata;
  logic [2*PIX_W-1:0]     lb_wdata;
  logic [PIX_W-1:0]       lb0_pix;
  logic [PIX_W-1:0]       lb1_pix;

  // A qualified sof forces the current pixel to (0,0) regardless of where
  // the counters were; it also takes priority over a row/frame wrap.
  always_comb begin
    cur_col = bus.sof ? '0 : col_q;
    cur_row = bus.sof ? '0 : row_q;
  end

  // Low half is row r-1, high half is row r-2. Writing {old r-1, pixel}
  // ages both lines by one row in a single access.
  assign lb0_pix  = lb_rdata[PIX_W-1:0];
  assign lb1_pix  = lb_rdata[2*PIX_W-1:PIX_W];
  assign lb_wdata = {lb0_pix, bus.pix_in};

  window3x3_gen_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (2 * PIX_W)
  ) u_line_buffer (
    .clk   (clk),
    .en    (bus.pix_valid),
    .addr  (cur_col),
    .wdata (lb_wdata),
    .rdata (lb_rdata)
  );

  // Counters, window shift and output flags. Columns 0 and 1 shift stale
  // data from the previous row into the window; win_valid masks those.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (bus.pix_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_ONE;
      end else begin
        col_d = cur_col + COL_ONE;
        row_d = cur_row;
      end
      win_d = {win_q[2], win_q[3], lb1_pix,
               win_q[5], win_q[6], lb0_pix,
               win_q[8], win_q[9], bus.pix_in};
      win_valid_d  = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.p1         = win_q[1];
  assign bus.p2         = win_q[2];
  assign bus.p3         = win_q[3];
  assign bus.p4         = win_q[4];
  assign bus.p5         = win_q[5];
  assign bus.p6         = win_q[6];
  assign bus.p7         = win_q[7];
  assign bus.p8         = win_q[8];
  assign bus.p9         = win_q[9];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// ---------------------------------------------------------------------------
// tb_window3x3_gen
// Directed bench for window3x3_gen on a 4x4 image where pixel(r,c) = 16r+c.
// Windows of such a frame appear after pixels 10, 11, 14 and 15 (row-major
// index) and are listed by hand in exp_win.
// ---------------------------------------------------------------------------
module tb_window3x3_gen;
  import window3x3_gen_pkg::*;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int PIX_W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  win_t exp_win [0:3];
  win_t obs_win;

  window3x3_gen_if #(.PIX_W(PIX_W)) bus ();

  window3x3_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign obs_win = {bus.p1, bus.p2, bus.p3, bus.p4, bus.p5,
                    bus.p6, bus.p7, bus.p8, bus.p9};

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] pix_val(input int k);
    return 8'((k / IMG_W) * 16 + (k % IMG_W));
  endfunction

  // Which hand-listed window follows row-major pixel k, or -1 for none
  function automatic int win_index(input int k);
    case (k)
      10:      return 0;
      11:      return 1;
      14:      return 2;
      15:      return 3;
      default: return -1;
    endcase
  endfunction

  // Present one input cycle at the falling edge, then wait until just after
  // the rising edge that consumes it
  task automatic apply_stimulus(input logic valid, input logic sof,
                                input logic [7:0] data);
    @(negedge clk);
    bus.pix_valid = valid;
    bus.sof       = sof;
    bus.pix_in    = data;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.pix_in    = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.sof       = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.win_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_win_valid got %b expected 0", bus.win_valid);
    end
    checks++;
    if (bus.frame_done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_frame_done got %b expected 0", bus.frame_done);
    end
    checks++;
    if (obs_win !== '0) begin
      errors++; $display("[TB] FAIL reset_window got %h expected 0", obs_win);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    int n_win;
    n_win = 0;
    for (int k = 0; k < 16; k++) begin
      int idx;
      apply_stimulus(1'b1, k == 0, pix_val(k));
      idx = win_index(k);
      if (bus.win_valid === 1'b1) n_win++;
      checks++;
      if (bus.win_valid !== (idx >= 0)) begin
        errors++; $display("[TB] FAIL fill_win_valid k=%0d got %b expected %b", k, bus.win_valid, idx >= 0);
      end
      checks++;
      if (bus.frame_done !== (k == 15)) begin
        errors++; $display("[TB] FAIL fill_frame_done k=%0d got %b expected %b", k, bus.frame_done, k == 15);
      end
      if (idx >= 0) begin
        checks++;
        if (obs_win !== exp_win[idx]) begin
          errors++; $display("[TB] FAIL fill_window k=%0d got %h expected %h", k, obs_win, exp_win[idx]);
        end
      end
    end
    checks++;
    if (n_win != 4) begin
      errors++; $display("[TB] FAIL fill_window_count got %0d expected 4", n_win);
    end
    go_idle();
  endtask

  task automatic test_stalls();
    int   k;
    int   guard;
    int   n_win;
    logic force_stall;
    logic have_exp;
    win_t last_exp;
    k           = 0;
    guard       = 0;
    n_win       = 0;
    force_stall = 1'b0;
    have_exp    = 1'b0;
    last_exp    = '0;
    while (k < 16 && guard < 300) begin
      guard++;
      if (force_stall || ($urandom_range(0, 1) == 0)) begin
        apply_stimulus(1'b0, 1'b0, 8'hA5);
        force_stall = 1'b0;
        checks++;
        if (bus.win_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL stall_win_valid k=%0d got %b expected 0", k, bus.win_valid);
        end
        checks++;
        if (bus.frame_done !== 1'b0) begin
          errors++; $display("[TB] FAIL stall_frame_done k=%0d got %b expected 0", k, bus.frame_done);
        end
        if (have_exp) begin
          checks++;
          if (obs_win !== last_exp) begin
            errors++; $display("[TB] FAIL stall_hold k=%0d got %h expected %h", k, obs_win, last_exp);
          end
        end
      end else begin
        int idx;
        apply_stimulus(1'b1, k == 0, pix_val(k));
        idx = win_index(k);
        if (bus.win_valid === 1'b1) n_win++;
        checks++;
        if (bus.win_valid !== (idx >= 0)) begin
          errors++; $display("[TB] FAIL stall_pix_valid k=%0d got %b expected %b", k, bus.win_valid, idx >= 0);
        end
        checks++;
        if (bus.frame_done !== (k == 15)) begin
          errors++; $display("[TB] FAIL stall_pix_done k=%0d got %b expected %b", k, bus.frame_done, k == 15);
        end
        if (idx >= 0) begin
          checks++;
          if (obs_win !== exp_win[idx]) begin
            errors++; $display("[TB] FAIL stall_window k=%0d got %h expected %h", k, obs_win, exp_win[idx]);
          end
          last_exp    = exp_win[idx];
          have_exp    = 1'b1;
          force_stall = 1'b1;
        end else begin
          have_exp = 1'b0;
        end
        k++;
      end
    end
    checks++;
    if (k != 16) begin
      errors++; $display("[TB] FAIL stall_progress got %0d expected 16", k);
    end
    checks++;
    if (n_win != 4) begin
      errors++; $display("[TB] FAIL stall_window_count got %0d expected 4", n_win);
    end
    go_idle();
  endtask

  task automatic test_row_wrap();
    for (int k = 0; k < 16; k++) begin
      apply_stimulus(1'b1, k == 0, pix_val(k));
      if (k == 11) begin
        checks++;
        if (bus.p1 !== 8'h01 || bus.p5 !== 8'h12) begin
          errors++; $display("[TB] FAIL wrap_2_3 got p1=%h p5=%h expected p1=01 p5=12", bus.p1, bus.p5);
        end
      end
      if (k == 12 || k == 13) begin
        checks++;
        if (bus.win_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL wrap_no_window k=%0d got %b expected 0", k, bus.win_valid);
        end
      end
      if (k == 14) begin
        checks++;
        if (bus.p1 !== 8'h10 || bus.p5 !== 8'h21 || bus.win_valid !== 1'b1) begin
          errors++; $display("[TB] FAIL wrap_3_2 got p1=%h p5=%h v=%b expected p1=10 p5=21 v=1", bus.p1, bus.p5, bus.win_valid);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_resync();
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, k == 0, pix_val(k));
      checks++;
      if (bus.win_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL resync_pre k=%0d got %b expected 0", k, bus.win_valid);
      end
    end
    for (int j = 0; j < 16; j++) begin
      int idx;
      apply_stimulus(1'b1, j == 0, pix_val(j));
      idx = win_index(j);
      checks++;
      if (bus.win_valid !== (idx >= 0)) begin
        errors++; $display("[TB] FAIL resync_win_valid j=%0d got %b expected %b", j, bus.win_valid, idx >= 0);
      end
      if (j == 10) begin
        checks++;
        if (bus.p5 !== 8'h11 || obs_win !== exp_win[0]) begin
          errors++; $display("[TB] FAIL resync_first_window got %h expected %h", obs_win, exp_win[0]);
        end
      end
      if (j == 15) begin
        checks++;
        if (bus.frame_done !== 1'b1) begin
          errors++; $display("[TB] FAIL resync_frame_done got %b expected 1", bus.frame_done);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 12; k++) begin
      apply_stimulus(1'b1, k == 0, pix_val(k));
    end
    checks++;
    if (bus.win_valid !== 1'b1 || obs_win !== exp_win[1]) begin
      errors++; $display("[TB] FAIL pre_reset_window got %h v=%b expected %h v=1", obs_win, bus.win_valid, exp_win[1]);
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    rst           = 1'b0;
    #1;
    checks++;
    if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset_flags got v=%b fd=%b expected 0 0", bus.win_valid, bus.frame_done);
    end
    checks++;
    if (obs_win !== '0) begin
      errors++; $display("[TB] FAIL async_reset_window got %h expected 0", obs_win);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 16; j++) begin
      int idx;
      apply_stimulus(1'b1, 1'b0, pix_val(j));
      idx = win_index(j);
      checks++;
      if (bus.win_valid !== (idx >= 0)) begin
        errors++; $display("[TB] FAIL post_reset_win_valid j=%0d got %b expected %b", j, bus.win_valid, idx >= 0);
      end
      if (j == 10) begin
        checks++;
        if (obs_win !== exp_win[0]) begin
          errors++; $display("[TB] FAIL post_reset_window got %h expected %h", obs_win, exp_win[0]);
        end
      end
      if (j == 15) begin
        checks++;
        if (bus.frame_done !== 1'b1) begin
          errors++; $display("[TB] FAIL post_reset_frame_done got %b expected 1", bus.frame_done);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int n_win;
    int n_done;
    int done_pos [2];
    n_win       = 0;
    n_done      = 0;
    done_pos[0] = 0;
    done_pos[1] = 0;
    for (int k = 0; k < 32; k++) begin
      int idx;
      apply_stimulus(1'b1, (k % 16) == 0, pix_val(k % 16));
      idx = win_index(k % 16);
      if (bus.win_valid === 1'b1) n_win++;
      if (bus.frame_done === 1'b1) begin
        if (n_done < 2) done_pos[n_done] = k;
        n_done++;
      end
      if (idx >= 0) begin
        checks++;
        if (bus.win_valid !== 1'b1 || obs_win !== exp_win[idx]) begin
          errors++; $display("[TB] FAIL b2b_window k=%0d got %h v=%b expected %h v=1", k, obs_win, bus.win_valid, exp_win[idx]);
        end
      end
    end
    checks++;
    if (n_win != 8) begin
      errors++; $display("[TB] FAIL b2b_window_count got %0d expected 8", n_win);
    end
    checks++;
    if (n_done != 2) begin
      errors++; $display("[TB] FAIL b2b_done_count got %0d expected 2", n_done);
    end
    checks++;
    if (done_pos[1] - done_pos[0] != 16) begin
      errors++; $display("[TB] FAIL b2b_done_spacing got %0d expected 16", done_pos[1] - done_pos[0]);
    end
    go_idle();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_win[0] = 72'h00_01_02_10_11_12_20_21_22;
    exp_win[1] = 72'h01_02_03_11_12_13_21_22_23;
    exp_win[2] = 72'h10_11_12_20_21_22_30_31_32;
    exp_win[3] = 72'h11_12_13_21_22_23_31_32_33;

    test_reset();
    test_fill();
    test_stalls();
    test_row_wrap();
    test_resync();
    test_reset_mid_frame();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
